ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2400, the clk_i cycles the PS/2 clock is held low before the request-to-send (100 us at 24 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 48000, the maximum clk_i cycles allowed between device clock falling edges before abort (2 ms at 24 MHz).
REQ-003 SHALL have port clk_i  in  1  system clock, the only clock.
REQ-004 SHALL have port reset_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port data_i  in  8  command byte to the keyboard, sampled on an accepted send_i.
REQ-006 SHALL have port send_i  in  1  one-cycle transmit request.
REQ-007 SHALL have port busy_o  out  1  transfer in progress.
REQ-008 SHALL have port done_o  out  1  one-cycle pulse on successful completion.
REQ-009 SHALL have port error_o  out  1  one-cycle pulse on timeout or missing ack.
REQ-010 SHALL have ports ps2_clk_i and ps2_dat_i  in  1 each  raw bus line levels, asynchronous.
REQ-011 SHALL have ports ps2_clk_oe_o and ps2_dat_oe_o  out  1 each  1 = pull the line low; 0 = release it to high-Z.

Function
REQ-012 SHALL pass ps2_clk_i and ps2_dat_i through 2-flop synchronizers; a falling edge is synchronized clock 1 then 0 on consecutive cycles.
REQ-013 SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE.
REQ-014 In IDLE, with send_i=1: latch data_i, compute odd parity (~^data_i), go to INHIBIT, assert busy_o on the next cycle.
REQ-015 SHALL ignore send_i whenever busy_o=1.
REQ-016 INHIBIT: ps2_clk_oe_o=1 for exactly INHIBIT_CYCLES cycles; ps2_dat_oe_o=1 on the final cycle (start bit 0); then REQ.
REQ-017 REQ: ps2_clk_oe_o=0, ps2_dat_oe_o=1; go to SHIFT on the first cycle.
REQ-018 SHIFT: a 4-bit counter counts falling edges. Edges 1-8 drive D0..D7 (LSB first), edge 9 drives parity, and edge 10 releases data (stop bit). The wire is driven low when ps2_dat_oe_o = ~bit.
REQ-019 After edge 10, go to ACK. ACK: on the next falling edge, sample synchronized data; 0 = ack OK.
REQ-020 RELEASE: wait until both synchronized lines are 1, then pulse done_o (ack OK) or error_o (no ack), clear busy_o, and return to IDLE in the same cycle.
REQ-021 A watchdog counter SHALL reset on every falling edge and on entry to REQ. If it reaches TIMEOUT_CYCLES in REQ, SHIFT or ACK, the block releases both lines, pulses error_o, and returns to IDLE.
REQ-022 done_o and error_o SHALL never assert in the same cycle, and each SHALL be exactly 1 cycle wide.
REQ-023 send_i arriving in the same cycle that done_o or error_o pulses SHALL be ignored; it is accepted from the next IDLE cycle.
REQ-024 Line glitches during INHIBIT SHALL be ignored: no edge counting occurs outside SHIFT and ACK.

Reset
REQ-025 SHALL on reset_i=1 enter IDLE and clear the counters, shift register and synchronizers (to 1).
REQ-026 SHALL on reset_i=1 drive busy_o=0, done_o=0, error_o=0, ps2_clk_oe_o=0, ps2_dat_oe_o=0.
REQ-027 Reset mid-transfer SHALL release both lines on the next cycle without pulsing done_o or error_o.

Configuration
REQ-028 Macro PS2_TX_ACK_CHECK_EN, when defined, enables the ack sampling of REQ-019; a 1 there yields error_o.
REQ-029 Without PS2_TX_ACK_CHECK_EN, the ACK state still waits for the 11th falling edge, but the sampled level is ignored and RELEASE always yields done_o. The timeout still applies.

Verification
REQ-030 Bench setup: INHIBIT_CYCLES=16, TIMEOUT_CYCLES=400, device model clock period 80 cycles. Send 0xED, model acks -> model receives bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done_o pulses once; clk held low exactly 16 cycles.
REQ-031 Send 0x00, model acks -> parity bit 1; done_o pulses; busy_o high from the cycle after send_i until the done_o cycle.
REQ-032 Send 0xFF with the ack bit left high -> with PS2_TX_ACK_CHECK_EN, error_o pulses; without it, done_o pulses.
REQ-033 Model stops clocking after edge 4 -> error_o pulses 400 cycles later; both oe outputs are 0 afterwards.
REQ-034 Second send_i during busy, then reset_i asserted at edge 6 -> second byte never sent; lines released one cycle after reset; no done_o or error_o pulse.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter.
//
// Sends one command byte to a PS/2 device. The host holds the bus clock low,
// places the start bit, releases the clock, and then shifts the data bits,
// the odd parity bit and the stop bit, one per device clock falling edge. It
// samples the device ack on the 11th falling edge and reports the result once
// both lines have returned high.
//
// Optional feature macro: PS2_TX_ACK_CHECK_EN
//   defined   : a high ack bit ends the transfer with error_o.
//   undefined : the ack level is ignored and a completed frame gives done_o.
//
// Ports
//   clk_i, reset_i              system clock, synchronous active-high reset
//   data_i[7:0], send_i         command byte, one-cycle send request
//   busy_o, done_o, error_o     status; done_o and error_o are 1-cycle pulses
//   ps2_clk_i, ps2_dat_i        raw bus levels (asynchronous)
//   ps2_clk_oe_o, ps2_dat_oe_o  1 = pull the line low, 0 = release
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2400,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       send_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic              clk_meta_q, clk_sync_q, clk_prev_q;
  logic              dat_meta_q, dat_sync_q;
  logic [INH_W-1:0]  inh_q, inh_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [9:0]        sr_q, sr_d;      // {stop, parity, data}, shifted out LSB first
  logic              bit_q, bit_d;    // level currently presented on the data line
  logic              ack_ok_q, ack_ok_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              fall;

  // Falling edge of the synchronized device clock.
  assign fall = clk_prev_q & ~clk_sync_q;

  // State register and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      inh_q      <= '0;
      wd_q       <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      bit_q      <= 1'b0;
      ack_ok_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
      inh_q      <= inh_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      bit_q      <= bit_d;
      ack_ok_q   <= ack_ok_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    inh_d    = inh_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    ack_ok_d = ack_ok_q;
    done_d   = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A request landing on the completion pulse cycle is dropped.
        if (send_i && !done_q && !error_q) begin
          sr_d     = {1'b1, ~^data_i, data_i};
          bit_d    = 1'b0;          // start bit
          inh_d    = '0;
          cnt_d    = '0;
          ack_ok_d = 1'b0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          wd_d    = '0;
          state_d = S_REQ;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_REQ: begin
        wd_d    = fall ? '0 : wd_q + 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        wd_d = fall ? '0 : wd_q + 1'b1;
        if (fall) begin
          bit_d = sr_q[0];
          sr_d  = {1'b1, sr_q[9:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 4'd9) state_d = S_ACK;   // edge 10 put the stop bit out
        end
      end
      S_ACK: begin
        wd_d = fall ? '0 : wd_q + 1'b1;
        if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          ack_ok_d = ~dat_sync_q;
`else
          ack_ok_d = 1'b1;
`endif
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = ack_ok_q;
          error_d = ~ack_ok_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog overrides everything while waiting on the device clock.
    if ((state_q == S_REQ || state_q == S_SHIFT || state_q == S_ACK) &&
        wd_q == WD_MAX) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      error_d = 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    busy_o       = (state_q != S_IDLE);
    done_o       = done_q;
    error_o      = error_q;
    ps2_clk_oe_o = (state_q == S_INHIBIT);
    ps2_dat_oe_o = 1'b0;
    case (state_q)
      S_INHIBIT: ps2_dat_oe_o = (inh_q == INH_LAST);
      S_REQ:     ps2_dat_oe_o = 1'b1;
      S_SHIFT:   ps2_dat_oe_o = ~bit_q;
      default:   ps2_dat_oe_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks each frame in,
// checking received bits against a queue of frames pushed when send_i is driven.
module tb_ps2_host_tx;

  localparam int INH  = 16;
  localparam int TMO  = 400;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       busy, done, error, clk_oe, dat_oe;
  logic       dev_clk_pull = 1'b0;
  logic       dev_dat_pull = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = ~(clk_oe | dev_clk_pull);
  assign dat_line = ~(dat_oe | dev_dat_pull);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .reset_i(reset), .data_i(data), .send_i(send),
    .busy_o(busy), .done_o(done), .error_o(error),
    .ps2_clk_i(clk_line), .ps2_dat_i(dat_line),
    .ps2_clk_oe_o(clk_oe), .ps2_dat_oe_o(dat_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] last_rx = '0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
  int run = 0, last_run = 0, inh_starts = 0, t_edge4 = 0;
  bit edge6 = 1'b0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  // Bus monitor: pulse counting and inhibit-length measurement.
  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
    if (done === 1'b1 && error === 1'b1) both_cnt++;
    if ((done === 1'b1 && prev_done) || (error === 1'b1 && prev_err)) wide_cnt++;
    prev_done = (done === 1'b1);
    prev_err  = (error === 1'b1);
    if (clk_oe === 1'b1) begin
      if (run == 0) inh_starts++;
      run++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  // Device model: waits for request-to-send, generates n_edges clock pulses,
  // samples data on each rising edge, optionally acks on the 11th pulse.
  task automatic device_rx(input int n_edges, input bit ack, input int ncmp);
    logic [9:0] rx, ex, mask;
    int w;
    rx = '0; mask = '0;
    for (int i = 0; i < ncmp && i < 10; i++) mask[i] = 1'b1;
    w = 0;
    while (clk_oe !== 1'b1 && w < 600) begin @(negedge clk); w++; end
    checks++;
    if (clk_oe !== 1'b1) begin
      errors++; $display("FAIL dev_inhibit: clk_oe=%b required 1", clk_oe); return;
    end
    w = 0;
    while (clk_oe === 1'b1 && w < 200) begin @(negedge clk); w++; end
    checks++;
    if (clk_oe !== 1'b0 || dat_oe !== 1'b1) begin
      errors++; $display("FAIL dev_rts: clk_oe=%b dat_oe=%b required 0/1", clk_oe, dat_oe);
    end
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11) dev_dat_pull = ack;
      repeat (HALF) @(negedge clk);
      dev_clk_pull = 1'b1;
      if (k == 4) t_edge4 = cyc;
      if (k == 6) edge6 = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_pull = 1'b0;
      if (k <= 10) rx[k-1] = dat_line;
    end
    dev_dat_pull = 1'b0;
    last_rx = rx;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty: got frame %h required a queued frame", rx);
    end else begin
      ex = exp_q.pop_front();
      if ((rx & mask) !== (ex & mask)) begin
        errors++; $display("FAIL frame: got %b required %b (mask %b)", rx, ex, mask);
      end
    end
  endtask

  task automatic host_send(input logic [7:0] b);
    @(negedge clk);
    data = b; send = 1'b1;
    exp_q.push_back({1'b1, ~^b, b});
    @(negedge clk);
    send = 1'b0;
  endtask

  // Waits for done_o/error_o, counting cycles where busy_o dropped early.
  task automatic wait_end(output int res, output int drops);
    res = 0; drops = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin res = 1; break; end
      if (error === 1'b1) begin res = 2; break; end
      if (busy !== 1'b1) drops++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks += 5;
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    if (error !== 1'b0)  begin errors++; $display("FAIL reset_error: got %b required 0", error); end
    if (clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b required 0", clk_oe); end
    if (dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe: got %b required 0", dat_oe); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Full transfer; poke drives send_i on the completion cycle, which must be dropped.
  task automatic test_send(input string name, input logic [7:0] b, input bit ack,
                           input bit want_done, input bit poke);
    int d0, e0, s0, res, drops;
    d0 = done_cnt; e0 = err_cnt;
    res = 0; drops = 0;
    fork
      device_rx(11, ack, 10);
      begin
        host_send(b);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_start: got %b required 1", name, busy); end
        wait_end(res, drops);
        checks += 3;
        if (res != (want_done ? 1 : 2)) begin
          errors++; $display("FAIL %s_outcome: got %0d required %0d (1=done 2=error 0=none)", name, res, want_done ? 1 : 2);
        end
        if (drops != 0) begin errors++; $display("FAIL %s_busy_window: got %0d early drops required 0", name, drops); end
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b required 0", name, busy); end
        if (poke) begin
          s0 = inh_starts;
          data = 8'hA5; send = 1'b1;
          @(negedge clk);
          send = 1'b0;
          repeat (40) @(negedge clk);
          checks++;
          if (busy !== 1'b0 || inh_starts != s0) begin
            errors++; $display("FAIL %s_send_on_done: busy=%b new_inhibits=%0d required 0/0", name, busy, inh_starts - s0);
          end
        end
      end
    join
    repeat (5) @(negedge clk);
    checks += 4;
    if (done_cnt - d0 != (want_done ? 1 : 0)) begin
      errors++; $display("FAIL %s_done_pulses: got %0d required %0d", name, done_cnt - d0, want_done ? 1 : 0);
    end
    if (err_cnt - e0 != (want_done ? 0 : 1)) begin
      errors++; $display("FAIL %s_error_pulses: got %0d required %0d", name, err_cnt - e0, want_done ? 0 : 1);
    end
    if (both_cnt != 0) begin errors++; $display("FAIL %s_done_and_error: got %0d required 0", name, both_cnt); end
    if (wide_cnt != 0) begin errors++; $display("FAIL %s_pulse_width: got %0d wide required 0", name, wide_cnt); end
  endtask

  task automatic test_timeout();
    int d0, e0, res, drops, t;
    d0 = done_cnt; e0 = err_cnt; t = 0; res = 0; drops = 0;
    fork
      device_rx(4, 1'b0, 4);
      begin
        host_send(8'h5A);
        wait_end(res, drops);
        t = cyc;
      end
    join
    checks += 4;
    if (res != 2) begin errors++; $display("FAIL timeout_outcome: got %0d required 2", res); end
    if (t - t_edge4 < TMO || t - t_edge4 > TMO + 10) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", t - t_edge4, TMO, TMO + 10);
    end
    if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin
      errors++; $display("FAIL timeout_release: clk_oe=%b dat_oe=%b required 0/0", clk_oe, dat_oe);
    end
    repeat (5) @(negedge clk);
    if (done_cnt != d0 || err_cnt - e0 != 1) begin
      errors++; $display("FAIL timeout_pulses: done=%0d error=%0d required 0/1", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    int d0, e0, s0, w;
    d0 = done_cnt; e0 = err_cnt;
    edge6 = 1'b0;
    fork
      device_rx(6, 1'b0, 5);
      begin
        host_send(8'h3C);
        repeat (30) @(negedge clk);
        data = 8'hC3; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        w = 0;
        while (!edge6 && w < 2000) begin @(negedge clk); w++; end
        checks++;
        if (!edge6) begin errors++; $display("FAIL reset_mid_edge6: edge 6 not reached in %0d cycles", w); end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (clk_oe !== 1'b0 || dat_oe !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL reset_mid_release: clk_oe=%b dat_oe=%b busy=%b required 0/0/0", clk_oe, dat_oe, busy);
        end
      end
    join
    s0 = inh_starts;
    repeat (300) @(negedge clk);
    checks += 2;
    if (inh_starts != s0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_second_byte: new_inhibits=%0d busy=%b required 0/0", inh_starts - s0, busy);
    end
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL reset_mid_pulses: done=%0d error=%0d required 0/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();

    test_send("send_ed", 8'hED, 1'b1, 1'b1, 1'b0);
    checks += 2;
    if (last_rx !== 10'b11_1110_1101) begin
      errors++; $display("FAIL ed_frame_bits: got %b required %b", last_rx, 10'b11_1110_1101);
    end
    if (last_run != INH) begin
      errors++; $display("FAIL ed_inhibit_len: got %0d cycles required %0d", last_run, INH);
    end

    test_send("send_00", 8'h00, 1'b1, 1'b1, 1'b1);
    checks++;
    if (last_rx !== 10'b11_0000_0000) begin
      errors++; $display("FAIL zero_frame_bits: got %b required %b", last_rx, 10'b11_0000_0000);
    end

`ifdef PS2_TX_ACK_CHECK_EN
    test_send("send_ff_noack", 8'hFF, 1'b0, 1'b0, 1'b0);
`else
    test_send("send_ff_noack", 8'hFF, 1'b0, 1'b1, 1'b0);
`endif

    test_timeout();
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d frames required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
